// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and default count width.
package countdown_timer_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/countdown_core.sv
// WIDTH-bit count register with clear, load, hold and decrement controls plus a zero flag.
module countdown_core #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             decrement,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (decrement) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-cycle done pulse on expiry.
// Optional periodic mode: define COUNTDOWN_TIMER_AUTO_RELOAD_EN to reload on expiry.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             abort,
    output logic [WIDTH-1:0] count_out,
    output logic             busy,
    output logic             done
);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   reload_reg;
    logic [WIDTH-1:0]   reload_next;
    logic               busy_next;
    logic               done_next;
    logic               core_clear;
    logic               core_load;
    logic               core_dec;
    logic [WIDTH-1:0]   core_src;
    logic               zero;

    countdown_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clock      (clock),
        .reset      (reset),
        .clear      (core_clear),
        .load       (core_load),
        .load_value (core_src),
        .decrement  (core_dec),
        .count      (count_out),
        .zero       (zero)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= ST_IDLE;
            reload_reg <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            reload_reg <= reload_next;
            busy       <= busy_next;
            done       <= done_next;
        end
    end

    always_comb begin
        state_next  = state;
        reload_next = reload_reg;
        busy_next   = busy;
        done_next   = 1'b0;
        core_clear  = 1'b0;
        core_load   = 1'b0;
        core_dec    = 1'b0;
        core_src    = load_value;

        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    core_load   = 1'b1;
                    reload_next = load_value;
                    busy_next   = 1'b1;
                    state_next  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    core_clear = 1'b1;
                    busy_next  = 1'b0;
                    state_next = ST_IDLE;
                end else if (enable) begin
                    if (!zero) begin
                        core_dec = 1'b1;
                    end else begin
                        // Expiry: the count sits at 0 for one enabled cycle before done fires.
                        done_next = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
                        core_load = 1'b1;
                        core_src  = reload_reg;
`else
                        busy_next  = 1'b0;
                        state_next = ST_IDLE;
`endif
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (WIDTH=4); covers both reload builds.
module tb_countdown_timer;

    localparam int unsigned WIDTH = 4;

    logic             clock;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] load_value;
    logic             enable;
    logic             abort;
    logic [WIDTH-1:0] count_out;
    logic             busy;
    logic             done;

    int unsigned vectors;
    int unsigned miscompares;

    countdown_timer #(
        .WIDTH(WIDTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .load_value (load_value),
        .enable     (enable),
        .abort      (abort),
        .count_out  (count_out),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just past it so outputs are sampled off-edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string tag, input int unsigned c, input int unsigned b,
                              input int unsigned d);
        check({tag, ".count"}, count_out, c);
        check({tag, ".busy"}, busy, b);
        check({tag, ".done"}, done, d);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        start       = 1'b0;
        load_value  = '0;
        enable      = 1'b0;
        abort       = 1'b0;

        tick();
        tick();
        expect_out("reset", 0, 0, 0);

        // Basic: load 3, enable held high.
        reset = 1'b1; start = 1'b1; load_value = 4'd3; enable = 1'b1;
        tick();
        start = 1'b0;
        expect_out("basic_load", 3, 1, 0);
        tick(); expect_out("basic_2", 2, 1, 0);
        tick(); expect_out("basic_1", 1, 1, 0);
        tick(); expect_out("basic_0", 0, 1, 0);
        tick(); expect_out("basic_done", 0, 0, 1);
        tick(); expect_out("basic_after", 0, 0, 0);

        // Stall: load 2, enable pattern 1,0,0,1,1.
        start = 1'b1; load_value = 4'd2;
        tick();
        start = 1'b0;
        expect_out("stall_load", 2, 1, 0);
        enable = 1'b1; tick(); expect_out("stall_e1", 1, 1, 0);
        enable = 1'b0; tick(); expect_out("stall_e0a", 1, 1, 0);
        enable = 1'b0; tick(); expect_out("stall_e0b", 1, 1, 0);
        enable = 1'b1; tick(); expect_out("stall_e1b", 0, 1, 0);
        enable = 1'b1; tick(); expect_out("stall_done", 0, 0, 1);

        // Stall while at zero delays done.
        start = 1'b1; load_value = 4'd1;
        tick();
        start = 1'b0;
        tick(); expect_out("zstall_0", 0, 1, 0);
        enable = 1'b0; tick(); expect_out("zstall_hold", 0, 1, 0);
        enable = 1'b1; tick(); expect_out("zstall_done", 0, 0, 1);

        // Abort at count 4 after loading 9.
        start = 1'b1; load_value = 4'd9;
        tick();
        start = 1'b0;
        expect_out("abort_load", 9, 1, 0);
        for (int i = 0; i < 5; i++) tick();
        expect_out("abort_pre", 4, 1, 0);
        abort = 1'b1; tick(); expect_out("abort_hit", 0, 0, 0);
        abort = 1'b0; tick(); expect_out("abort_after", 0, 0, 0);

        // start+abort together in IDLE: no load.
        start = 1'b1; abort = 1'b1; load_value = 4'd7;
        tick();
        expect_out("start_abort", 0, 0, 0);
        abort = 1'b0;

        // start in RUN is ignored.
        load_value = 4'd5;
        tick();
        expect_out("restart_load", 5, 1, 0);
        load_value = 4'd12;
        tick(); expect_out("restart_ign", 4, 1, 0);
        start = 1'b0;
        tick(); expect_out("restart_next", 3, 1, 0);

        // Reset mid-count overrides everything.
        reset = 1'b0; start = 1'b1;
        tick();
        tick();
        expect_out("midreset", 0, 0, 0);
        reset = 1'b1; load_value = 4'd1;
        tick();
        start = 1'b0;
        expect_out("post_reset_start", 1, 1, 0);
        tick(); expect_out("post_reset_0", 0, 1, 0);
        tick(); expect_out("post_reset_done", 0, 0, 1);

        // load 0: expiry on first enabled RUN cycle.
        start = 1'b1; load_value = 4'd0;
        tick();
        start = 1'b0;
        expect_out("zero_load", 0, 1, 0);
        tick(); expect_out("zero_done", 0, 0, 1);

        // load 15: 16 enabled cycles to done, no wrap.
        start = 1'b1; load_value = 4'd15;
        tick();
        start = 1'b0;
        expect_out("max_load", 15, 1, 0);
        for (int i = 1; i <= 15; i++) begin
            tick();
            check("max_count", count_out, 15 - i);
            check("max_done", done, 0);
        end
        tick(); expect_out("max_done_pulse", 0, 0, 1);
        tick(); expect_out("max_after", 0, 0, 0);

        // Reload behaviour: load 2, enable high.
        start = 1'b1; load_value = 4'd2;
        tick();
        start = 1'b0;
        expect_out("rl_load", 2, 1, 0);
        tick(); expect_out("rl_1", 1, 1, 0);
        tick(); expect_out("rl_0", 0, 1, 0);
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        tick(); expect_out("rl_done1", 2, 1, 1);
        tick(); expect_out("rl_1b", 1, 1, 0);
        tick(); expect_out("rl_0b", 0, 1, 0);
        tick(); expect_out("rl_done2", 2, 1, 1);
        abort = 1'b1; tick(); expect_out("rl_abort", 0, 0, 0);
        abort = 1'b0; tick(); expect_out("rl_stopped", 0, 0, 0);
`else
        tick(); expect_out("rl_done1", 0, 0, 1);
        tick(); expect_out("rl_idle", 0, 0, 0);
        tick(); expect_out("rl_idle2", 0, 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
